// File: rtl/mem_req_sequencer_if.sv
// CPU request/response channel plus the strobe bus toward the 16x16 memory controller.
// slave: the sequencer side; master: the CPU and controller side.
interface mem_req_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              MEMR;
  logic              MEMW;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DIN;
  logic [DATA_W-1:0] MEM_DOUT;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, MEM_DOUT,
    output req_ready, rsp_valid, rsp_rdata, MEMR, MEMW, MEM_ADDR, MEM_DIN
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, MEM_DOUT,
    input  req_ready, rsp_valid, rsp_rdata, MEMR, MEMW, MEM_ADDR, MEM_DIN
  );
endinterface

// File: rtl/mem_req_sequencer.sv
// Request FIFO and strobe sequencer in front of the 16x16 memory controller; reads block in order.
// Define MEM_SEQ_STAT_CNT_EN to add the saturating wr_cnt/rd_cnt statistics outputs.
module mem_req_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  mem_req_sequencer_if.slave     bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef MEM_SEQ_STAT_CNT_EN
  ,
  output logic [15:0]            wr_cnt,
  output logic [15:0]            rd_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  typedef enum logic [2:0] {StIdle, StWr, StRd, StCap, StRsp} state_e;

  entry_t            fifo_q [DEPTH];
  entry_t            head;
  entry_t            push_entry;
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              full, empty, push, pop, rsp_hs;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = bus.req_valid && !full;
  assign head       = fifo_q[rptr_q];
  assign push_entry = '{wr: bus.req_wr, addr: bus.req_addr, wdata: bus.req_wdata};
  assign rsp_hs     = (state_q == StRsp) && bus.rsp_ready;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_q[wptr_q] <= push_entry;
    end
  end

  // Pops happen only from IDLE or WR, so a read blocks the queue until its response is taken.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle, StWr: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = head.wr ? StWr : StRd;
        end else begin
          state_d = StIdle;
        end
      end
      StRd:    state_d = StCap;
      StCap:   state_d = StRsp;
      StRsp:   if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q     <= rptr_q + PtrW'(1);
        mem_addr_q <= head.addr;
        mem_din_q  <= head.wdata;
      end
      // Controller data_out is registered, so it is valid during the cycle after MEMR.
      if (state_q == StCap) begin
        rsp_rdata_q <= bus.MEM_DOUT;
      end
    end
  end

  assign bus.req_ready = !full;
  assign bus.MEMW      = (state_q == StWr);
  assign bus.MEMR      = (state_q == StRd);
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_DIN   = mem_din_q;
  assign bus.rsp_valid = (state_q == StRsp);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = !empty || (state_q != StIdle);
  assign fifo_count    = count_q;

`ifdef MEM_SEQ_STAT_CNT_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if ((state_q == StWr) && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if (rsp_hs && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`else
  logic unused_rsp_hs;
  assign unused_rsp_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: transaction-level model with a per-cycle compare plus directed checks.
module tb_mem_req_sequencer;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 4;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b1;
  logic        busy;
  logic [2:0]  fifo_count;
`ifdef MEM_SEQ_STAT_CNT_EN
  logic [15:0] wr_cnt, rd_cnt;
`endif
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  mem_req_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_req_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus),
    .busy       (busy),
`ifdef MEM_SEQ_STAT_CNT_EN
    .wr_cnt     (wr_cnt),
    .rd_cnt     (rd_cnt),
`endif
    .fifo_count (fifo_count)
  );

  // Controller stand-in: write commits on the MEMW edge, data_out registered on the MEMR edge.
  logic [DATA_W-1:0] ctrl_mem [16] = '{default: '0};
  logic [DATA_W-1:0] ctrl_dout = '0;
  always @(posedge CLK) begin
    if (bus.MEMW) ctrl_mem[bus.MEM_ADDR] <= bus.MEM_DIN;
    if (bus.MEMR) ctrl_dout <= ctrl_mem[bus.MEM_ADDR];
  end
  assign bus.MEM_DOUT = ctrl_dout;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: commands queue in acceptance order; a read's data is the program-order memory
  // value at acceptance. strobe 0/1/2 = none/write/read this cycle; rdwait 1 = capture, 2 = response.
  typedef struct {
    bit        wr;
    bit [3:0]  addr;
    bit [15:0] data;
    bit [15:0] exp;
  } cmd_t;

  cmd_t      q[$];
  bit [15:0] shadow [16];
  bit [15:0] commit_mem [16];
  int        m_strobe = 0;
  int        m_rdwait = 0;
  bit [3:0]  m_addr   = '0;
  bit [15:0] m_din    = '0;
  bit [15:0] m_rd_exp = '0;
  bit [15:0] m_rdata  = '0;
  int        m_wr_cnt = 0;
  int        m_rd_cnt = 0;

  initial begin : model
    bit   can_issue, accept, hs;
    cmd_t c;
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        q.delete();
        m_strobe = 0; m_rdwait = 0; m_addr = '0; m_din = '0; m_rdata = '0;
        m_wr_cnt = 0; m_rd_cnt = 0;
        shadow   = commit_mem;  // queued writes are discarded
      end else begin
        can_issue = (m_strobe != 2) && (m_rdwait == 0) && (q.size() > 0);
        accept    = bus.req_valid && (q.size() < DEPTH);
        hs        = (m_rdwait == 2) && bus.rsp_ready;
        if (m_strobe == 1) begin
          commit_mem[m_addr] = m_din;
          if (m_wr_cnt < 16'hFFFF) m_wr_cnt++;
        end
        if (hs) begin
          m_rdwait = 0;
          if (m_rd_cnt < 16'hFFFF) m_rd_cnt++;
        end else if (m_rdwait == 1) begin
          m_rdwait = 2;
          m_rdata  = m_rd_exp;
        end
        if (m_strobe == 2) m_rdwait = 1;
        m_strobe = 0;
        if (can_issue) begin
          c        = q.pop_front();
          m_strobe = c.wr ? 1 : 2;
          m_addr   = c.addr;
          m_din    = c.data;
          m_rd_exp = c.exp;
        end
        if (accept) begin
          c.wr   = bus.req_wr;
          c.addr = bus.req_addr;
          c.data = bus.req_wdata;
          c.exp  = shadow[bus.req_addr];
          if (bus.req_wr) shadow[bus.req_addr] = bus.req_wdata;
          q.push_back(c);
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge CLK);
      check("req_ready", 32'(bus.req_ready), 32'(q.size() < DEPTH));
      check("fifo_count", 32'(fifo_count), 32'(q.size()));
      check("busy", 32'(busy), 32'(q.size() > 0 || m_strobe != 0 || m_rdwait != 0));
      check("MEMW", 32'(bus.MEMW), 32'(m_strobe == 1));
      check("MEMR", 32'(bus.MEMR), 32'(m_strobe == 2));
      check("strobe_overlap", 32'(bus.MEMR && bus.MEMW), 32'(0));
      check("MEM_ADDR", 32'(bus.MEM_ADDR), 32'(m_addr));
      if (m_strobe == 1) check("MEM_DIN", 32'(bus.MEM_DIN), 32'(m_din));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rdwait == 2));
      check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
`ifdef MEM_SEQ_STAT_CNT_EN
      check("wr_cnt", 32'(wr_cnt), 32'(m_wr_cnt));
      check("rd_cnt", 32'(rd_cnt), 32'(m_rd_cnt));
`endif
    end
  end

  task automatic send(input bit wr, input bit [3:0] addr, input bit [15:0] data);
    bit hs = 1'b0;
    int n  = 0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    while (!hs) begin
      @(negedge CLK);
      hs = bus.req_ready;
      @(posedge CLK);
      #1;
      n++;
      if (!hs && n > 60) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
        break;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((busy || bus.rsp_valid) && n < 100);
    if (busy || bus.rsp_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0d rsp_valid=%0d, required 0/0", busy, bus.rsp_valid);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit        w4 [20];
    bit [3:0]  a4 [20];
    bit        b4 [20];
    int        first, last, cnt, n;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'(1));
    check("reset_fifo_count", 32'(fifo_count), 32'(0));

    // 1: write then read of the same address
    send(1'b1, 4'h3, 16'hA5A5);
    send(1'b0, 4'h3, 16'h0000);
    @(negedge CLK);
    check("t1_memw", 32'(bus.MEMW), 32'(1));
    check("t1_addr", 32'(bus.MEM_ADDR), 32'(4'h3));
    @(negedge CLK);
    check("t1_memr", 32'(bus.MEMR), 32'(1));
    @(negedge CLK);
    @(negedge CLK);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'(1));
    check("t1_rdata", 32'(bus.rsp_rdata), 32'(16'hA5A5));
    wait_idle();

    // 2: blocked read, five writes offered back to back
    bus.rsp_ready = 1'b0;
    fork
      begin
        send(1'b0, 4'h5, 16'h0000);
        for (int i = 0; i < 5; i++) send(1'b1, 4'(i), 16'h1000 + 16'(i));
      end
      begin
        repeat (10) @(negedge CLK);
        check("t2_ready_low", 32'(bus.req_ready), 32'(0));
        check("t2_full_count", 32'(fifo_count), 32'(4));
        @(posedge CLK);
        #1 bus.rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // 3: response held while consumer stalls
    bus.rsp_ready = 1'b0;
    send(1'b1, 4'h7, 16'hBEEF);
    send(1'b0, 4'h7, 16'h0000);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.rsp_valid && n < 20);
    repeat (5) begin
      @(negedge CLK);
      check("t3_valid_held", 32'(bus.rsp_valid), 32'(1));
      check("t3_rdata_held", 32'(bus.rsp_rdata), 32'(16'hBEEF));
      check("t3_no_strobe", 32'(bus.MEMR || bus.MEMW), 32'(0));
    end
    @(posedge CLK);
    #1 bus.rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("t3_done", 32'(bus.rsp_valid), 32'(0));
    wait_idle();

    // 4: four queued writes stream one per cycle
    fork
      for (int i = 0; i < 4; i++) send(1'b1, 4'h8 + 4'(i), 16'h4000 + 16'(i));
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        w4[i] = bus.MEMW;
        a4[i] = bus.MEM_ADDR;
        b4[i] = busy;
      end
    join
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (w4[i]) begin
        if (first < 0) first = i;
        last = i;
        check("t4_addr_order", 32'(a4[i]), 32'(4'h8 + 4'(cnt)));
        cnt++;
      end
    end
    check("t4_strobe_count", 32'(cnt), 32'(4));
    check("t4_consecutive", 32'(last - first), 32'(3));
    if (last >= 0 && last < 19) begin
      check("t4_busy_last", 32'(b4[last]), 32'(1));
      check("t4_busy_fall", 32'(b4[last+1]), 32'(0));
    end
    wait_idle();

    // 5: async reset while capturing read data, with writes still queued
    fork
      begin
        send(1'b0, 4'h3, 16'h5A5A);
        send(1'b1, 4'h1, 16'h1111);
        send(1'b1, 4'h2, 16'h2222);
      end
      begin
        n = 0;
        do begin
          @(negedge CLK);
          n++;
        end while (!bus.MEMR && n < 20);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("t5_memr", 32'(bus.MEMR), 32'(0));
        check("t5_memw", 32'(bus.MEMW), 32'(0));
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_mem_addr", 32'(bus.MEM_ADDR), 32'(0));
        check("t5_mem_din", 32'(bus.MEM_DIN), 32'(0));
        check("t5_rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
        check("t5_fifo_count", 32'(fifo_count), 32'(0));
      end
    join
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      check("t5_no_rsp", 32'(bus.rsp_valid), 32'(0));
      check("t5_empty", 32'(fifo_count), 32'(0));
    end
    @(posedge CLK);
    #1;

    // 6: three writes, two reads (addr 1 must show the discarded write never landed)
    send(1'b1, 4'hC, 16'hC0C0);
    send(1'b1, 4'hD, 16'hD0D0);
    send(1'b0, 4'h1, 16'h0000);
    send(1'b1, 4'hE, 16'hE0E0);
    send(1'b0, 4'hC, 16'h0000);
    wait_idle();
    check("t6_last_rdata", 32'(bus.rsp_rdata), 32'(16'hC0C0));
`ifdef MEM_SEQ_STAT_CNT_EN
    check("t6_wr_cnt", 32'(wr_cnt), 32'(3));
    check("t6_rd_cnt", 32'(rd_cnt), 32'(2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
